// File: rtl/t05_sram_arbiter.sv
// Round-robin arbiter sharing the single-port Huffman histogram/tree SRAM
// between the pipeline stages (0 histogram, 1 find-least, 2 tree builder,
// 3 codebook). One word transaction at a time: IDLE -> ISSUE -> (WAIT) -> DONE.
// Optional feature macro: T05_ARB_LOCK_EN (grant lock for atomic read-modify-write).
module t05_sram_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       wr_r_en,
    input  logic [AW*NREQ-1:0]      addr,
    input  logic [DW*NREQ-1:0]      wdata,
    input  logic [NREQ-1:0]         lock,
    output logic [NREQ-1:0]         ack,
    output logic [DW-1:0]           rdata,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    busy,
    output logic [AW-1:0]           sram_addr,
    output logic [DW-1:0]           sram_wdata,
    output logic [1:0]              sram_wr_r_en,
    input  logic [DW-1:0]           sram_rdata
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_WR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   rr_ptr, rr_n;
    logic [IW-1:0]   gnt_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NREQ-1:0] ack_n;
    logic [DW-1:0]   rdata_n;
    logic            busy_n;
    logic [AW-1:0]   sram_addr_n;
    logic [DW-1:0]   sram_wdata_n;
    logic [1:0]      sram_wr_r_en_n;
    logic [1:0]      win_op;

    logic [IW-1:0]   arb_start;
    logic [NREQ-1:0] req_eff;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   arb_win;
    logic            arb_found;

    // Wrapping successor of a requester index
    function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
        return (32'(id) == NREQ - 32'd1) ? '0 : IW'(32'(id) + 32'd1);
    endfunction

`ifdef T05_ARB_LOCK_EN
    logic lock_q, lock_n;
    logic hold;

    // While the last grantee keeps its lock, only it may be granted again
    assign hold      = lock_q & lock[gnt_id];
    assign arb_start = lock_q ? next_id(gnt_id) : rr_ptr;
    assign req_eff   = hold ? (req & (NREQ'(1) << gnt_id)) : req;

    // Lock flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_q <= 1'b0;
        else     lock_q <= lock_n;
    end
`else
    logic unused_lock;

    assign arb_start   = rr_ptr;
    assign req_eff     = req;
    assign unused_lock = ^lock;
`endif

    // Round-robin search: first active request at or after arb_start
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            arb_idx = IW'((32'(arb_start) + i) % NREQ);
            if (!arb_found && req_eff[arb_idx]) begin
                arb_found = 1'b1;
                arb_win   = arb_idx;
            end
        end
    end

    assign win_op = wr_r_en[32'(arb_win)*2 +: 2];

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_n        = state;
        rr_n           = rr_ptr;
        gnt_n          = gnt_id;
        cnt_n          = cnt;
        ack_n          = '0;
        rdata_n        = rdata;
        sram_addr_n    = sram_addr;
        sram_wdata_n   = sram_wdata;
        sram_wr_r_en_n = 2'b00;
`ifdef T05_ARB_LOCK_EN
        lock_n         = lock_q;
`endif
        case (state)
            S_IDLE: begin
`ifdef T05_ARB_LOCK_EN
                if (lock_q && !lock[gnt_id]) lock_n = 1'b0;
`endif
                if (arb_found) begin
                    state_n      = S_ISSUE;
                    gnt_n        = arb_win;
                    sram_addr_n  = addr[32'(arb_win)*AW +: AW];
                    sram_wdata_n = wdata[32'(arb_win)*DW +: DW];
                    // No-op codes never reach the SRAM
                    if (win_op == OP_RD || win_op == OP_WR) sram_wr_r_en_n = win_op;
                end
            end
            S_ISSUE: begin
                if (sram_wr_r_en == OP_RD) begin
                    state_n = S_WAIT;
                    cnt_n   = CW'(RD_LAT - 1);
                end else begin
                    state_n        = S_DONE;
                    ack_n[gnt_id]  = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_n       = S_DONE;
                    rdata_n       = sram_rdata;
                    ack_n[gnt_id] = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
`ifdef T05_ARB_LOCK_EN
                lock_n = lock[gnt_id];
                rr_n   = lock[gnt_id] ? rr_ptr : next_id(gnt_id);
`else
                rr_n   = next_id(gnt_id);
`endif
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // State and output registers; reset abandons any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            gnt_id       <= '0;
            cnt          <= '0;
            ack          <= '0;
            rdata        <= '0;
            busy         <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            sram_wr_r_en <= 2'b00;
        end else begin
            state        <= state_n;
            rr_ptr       <= rr_n;
            gnt_id       <= gnt_n;
            cnt          <= cnt_n;
            ack          <= ack_n;
            rdata        <= rdata_n;
            busy         <= busy_n;
            sram_addr    <= sram_addr_n;
            sram_wdata   <= sram_wdata_n;
            sram_wr_r_en <= sram_wr_r_en_n;
        end
    end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Directed self-checking bench for t05_sram_arbiter with a small SRAM model.
module tb_t05_sram_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = 32;
    localparam int unsigned RD_LAT = 1;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    wr_r_en;
    logic [AW*NREQ-1:0]   addr;
    logic [DW*NREQ-1:0]   wdata;
    logic [NREQ-1:0]      lock;
    logic [NREQ-1:0]      ack;
    logic [DW-1:0]        rdata;
    logic [1:0]           gnt_id;
    logic                 busy;
    logic [AW-1:0]        sram_addr;
    logic [DW-1:0]        sram_wdata;
    logic [1:0]           sram_wr_r_en;
    logic [DW-1:0]        sram_rdata;

    int checks   = 0;
    int failures = 0;

    t05_sram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .wr_r_en      (wr_r_en),
        .addr         (addr),
        .wdata        (wdata),
        .lock         (lock),
        .ack          (ack),
        .rdata        (rdata),
        .gnt_id       (gnt_id),
        .busy         (busy),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_wr_r_en (sram_wr_r_en),
        .sram_rdata   (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, unwritten 0x41 preloaded with 5
    logic [DW-1:0]  mem [256];
    logic [255:0]   mem_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid  <= '0;
            sram_rdata <= '0;
        end else begin
            if (sram_wr_r_en == 2'b10) begin
                mem[sram_addr]       <= sram_wdata;
                mem_valid[sram_addr] <= 1'b1;
            end
            if (sram_wr_r_en == 2'b01)
                sram_rdata <= mem_valid[sram_addr] ? mem[sram_addr]
                            : ((sram_addr == 8'h41) ? 32'd5 : {24'hDEAD00, sram_addr});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [31:0] d);
        req[i]            = 1'b1;
        wr_r_en[2*i +: 2] = op;
        addr[AW*i +: AW]  = a;
        wdata[DW*i +: DW] = d;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic int ack_idx(input logic [NREQ-1:0] a);
        for (int i = 0; i < NREQ; i++) if (a[i]) return i;
        return -1;
    endfunction

    // Wait (bounded) for the next ack pulse; -1 when the budget expires
    task automatic wait_ack(output int idx);
        idx = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                idx = ack_idx(ack);
                return;
            end
        end
    endtask

    int order [4];
    int n;
    int idx;
    logic first0;
    logic [NREQ-1:0] ack_seen;
    logic [DW-1:0]   mem41;

    initial begin
        rst = 1'b1; req = '0; lock = '0; wr_r_en = '0; addr = '0; wdata = '0;
        #1;
        check("reset_ack",   32'(ack), 0);
        check("reset_busy",  32'(busy), 0);
        check("reset_en",    32'(sram_wr_r_en), 0);
        check("reset_rdata", rdata, 0);
        do_reset();

        // 1: read 0x41 from requester 0
        set_req(0, 2'b01, 8'h41, 32'h0);
        @(negedge clk);
        check("t1_issue_en",   32'(sram_wr_r_en), 32'h1);
        check("t1_issue_addr", 32'(sram_addr), 32'h41);
        check("t1_busy",       32'(busy), 1);
        @(negedge clk);
        check("t1_wait_en",    32'(sram_wr_r_en), 0);
        check("t1_no_early",   32'(ack), 0);
        @(negedge clk);
        check("t1_ack",        32'(ack), 32'h1);
        check("t1_rdata",      rdata, 32'd5);
        check("t1_gnt",        32'(gnt_id), 0);
        req[0] = 1'b0;
        @(negedge clk);
        check("t1_ack_pulse",  32'(ack), 0);
        check("t1_idle_busy",  32'(busy), 0);

        // 2: write 6 to 0x41 from requester 0
        set_req(0, 2'b10, 8'h41, 32'd6);
        @(negedge clk);
        check("t2_issue_en",    32'(sram_wr_r_en), 32'h2);
        check("t2_issue_addr",  32'(sram_addr), 32'h41);
        check("t2_issue_wdata", sram_wdata, 32'd6);
        @(negedge clk);
        check("t2_ack",         32'(ack), 32'h1);
        check("t2_done_en",     32'(sram_wr_r_en), 0);
        req[0] = 1'b0;
        @(negedge clk);
        mem41 = mem_valid[8'h41] ? mem[8'h41] : 32'hFFFF_FFFF;
        check("t2_mem",         mem41, 32'd6);

        // 6: no-op from requester 3 leaves the SRAM and rdata alone
        set_req(3, 2'b11, 8'h22, 32'hAB);
        @(negedge clk);
        check("t6_issue_en",   32'(sram_wr_r_en), 0);
        check("t6_busy",       32'(busy), 1);
        @(negedge clk);
        check("t6_ack",        32'(ack), 32'h8);
        check("t6_gnt",        32'(gnt_id), 3);
        check("t6_rdata",      rdata, 32'd5);
        req[3] = 1'b0;
        @(negedge clk);

        // 3: all four write continuously, each drops after its ack
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2'b10, 8'(8'h10 + i), 32'(i + 100));
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                idx = ack_idx(ack);
                order[n] = idx;
                n++;
                check("t3_busy_at_ack", 32'(busy), 1);
                req[idx] = 1'b0;
            end
        end
        check("t3_count", 32'(n), 4);
        for (int k = 0; k < 4; k++) check($sformatf("t3_order%0d", k), 32'(order[k]), 32'(k));

        // 4: requester 0 read-then-write with lock, requester 1 pending
        do_reset();
        set_req(0, 2'b01, 8'h42, 32'h0);
        lock[0] = 1'b1;
        set_req(1, 2'b10, 8'h50, 32'h77);
        n = 0;
        first0 = 1'b1;
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                idx = ack_idx(ack);
                order[n] = idx;
                n++;
                if (idx == 0 && first0) begin
                    first0 = 1'b0;
                    set_req(0, 2'b10, 8'h42, 32'd9);
                end else if (idx == 0) begin
                    req[0]  = 1'b0;
                    lock[0] = 1'b0;
                end else begin
                    req[idx] = 1'b0;
                end
            end
        end
        check("t4_count", 32'(n), 3);
        check("t4_order0", 32'(order[0]), 0);
`ifdef T05_ARB_LOCK_EN
        check("t4_order1", 32'(order[1]), 0);
        check("t4_order2", 32'(order[2]), 1);
`else
        check("t4_order1", 32'(order[1]), 1);
        check("t4_order2", 32'(order[2]), 0);
`endif

        // 5: reset during a read wait abandons it and clears the pointer
        do_reset();
        set_req(1, 2'b10, 8'h10, 32'd1);
        wait_ack(idx);
        check("t5_pre_ack", 32'(idx), 1);
        req[1] = 1'b0;
        @(negedge clk);
        set_req(2, 2'b01, 8'h41, 32'h0);
        @(negedge clk);
        check("t5_issue_en", 32'(sram_wr_r_en), 32'h1);
        @(negedge clk);
        check("t5_in_wait_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("t5_rst_ack",   32'(ack), 0);
        check("t5_rst_busy",  32'(busy), 0);
        check("t5_rst_en",    32'(sram_wr_r_en), 0);
        check("t5_rst_gnt",   32'(gnt_id), 0);
        check("t5_rst_addr",  32'(sram_addr), 0);
        check("t5_rst_rdata", rdata, 0);
        req[2] = 1'b0;
        ack_seen = '0;
        @(negedge clk);
        ack_seen |= ack;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ack_seen |= ack;
        end
        check("t5_no_ack", 32'(ack_seen), 0);
        set_req(1, 2'b10, 8'h11, 32'd2);
        set_req(3, 2'b10, 8'h13, 32'd3);
        wait_ack(idx);
        check("t5_next_grant", 32'(idx), 1);
        req[1] = 1'b0;
        wait_ack(idx);
        check("t5_then_grant", 32'(idx), 3);
        req[3] = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
